// File: rtl/lsu_rmw.sv
// Load/store unit for the RV32 core: sub-word loads with extension and sub-word
// stores via read-modify-write against a word-only memory with req/ack handshake.
module lsu_rmw #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              fault,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, DONE = 2'd3} state_t;

    state_t            state_reg, state_next;
    logic              we_reg, we_next;
    logic [2:0]        funct3_reg, funct3_next;
    logic [1:0]        lane_reg, lane_next;
    logic [15:0]       wdata_reg, wdata_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              mem_req_reg, mem_req_next;
    logic              mem_we_reg, mem_we_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [31:0]       mem_wdata_reg, mem_wdata_next;
    logic [31:0]       rsp_rdata_reg, rsp_rdata_next;
    logic              rsp_valid_reg, rsp_valid_next;
    logic              fault_reg, fault_next;

    logic              legal_f3, misaligned, timed_out;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       load_value, merged;
    logic              unused_addr;

    assign unused_addr = ^req_addr[31:ADDR_W+2];

    assign stall     = req_valid & (state_reg != DONE);
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign fault     = fault_reg;
    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

    always_comb begin
        legal_f3 = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: legal_f3 = 1'b1;
            3'b100, 3'b101:         legal_f3 = ~req_we;
            default:                legal_f3 = 1'b0;
        endcase
        misaligned = ((req_funct3[1:0] == 2'b01) & req_addr[0]) |
                     ((req_funct3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));
    end

    assign timed_out = (cnt_reg == CNT_W'(TIMEOUT - 1));

    always_comb begin
        ld_byte    = 8'(mem_rdata >> {lane_reg, 3'b000});
        ld_half    = 16'(mem_rdata >> {lane_reg[1], 4'b0000});
        load_value = mem_rdata;
        case (funct3_reg)
            3'b000:  load_value = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_value = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_value = {24'b0, ld_byte};
            3'b101:  load_value = {16'b0, ld_half};
            default: load_value = mem_rdata;
        endcase
    end

    // Per byte lane: keep the old memory byte unless the store covers this lane.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic hit;
            assign hit = (funct3_reg[1:0] == 2'b00) ? (lane_reg == LANE)
                                                    : (lane_reg[1] == LANE[1]);
            assign merged[8*gi +: 8] = !hit ? mem_rdata[8*gi +: 8] :
                                       (funct3_reg[1:0] == 2'b00) ? wdata_reg[7:0]
                                                                  : wdata_reg[8*(gi%2) +: 8];
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        we_next        = we_reg;
        funct3_next    = funct3_reg;
        lane_next      = lane_reg;
        wdata_next     = wdata_reg;
        cnt_next       = cnt_reg;
        mem_req_next   = mem_req_reg;
        mem_we_next    = mem_we_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        rsp_rdata_next = rsp_rdata_reg;
        rsp_valid_next = 1'b0;
        fault_next     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    we_next       = req_we;
                    funct3_next   = req_funct3;
                    lane_next     = req_addr[1:0];
                    wdata_next    = req_wdata[15:0];
                    mem_addr_next = req_addr[ADDR_W+1:2];
                    cnt_next      = '0;
                    if (!legal_f3 || misaligned) begin
                        state_next     = DONE;
                        rsp_valid_next = 1'b1;
                        fault_next     = 1'b1;
                        rsp_rdata_next = '0;
                    end else if (!req_we || req_funct3 != 3'b010) begin
                        state_next   = RD;
                        mem_req_next = 1'b1;
                        mem_we_next  = 1'b0;
                    end else begin
                        state_next     = WR;
                        mem_req_next   = 1'b1;
                        mem_we_next    = 1'b1;
                        mem_wdata_next = req_wdata;
                    end
                end
            end
            RD: begin
                if (mem_ack) begin
                    cnt_next = '0;
                    if (!we_reg) begin
                        state_next     = DONE;
                        mem_req_next   = 1'b0;
                        rsp_valid_next = 1'b1;
                        rsp_rdata_next = load_value;
                    end else begin
                        // Request stays up; the same word is now written back merged.
                        state_next     = WR;
                        mem_we_next    = 1'b1;
                        mem_wdata_next = merged;
                    end
                end else if (timed_out) begin
                    state_next     = DONE;
                    mem_req_next   = 1'b0;
                    rsp_valid_next = 1'b1;
                    fault_next     = 1'b1;
                    rsp_rdata_next = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            WR: begin
                if (mem_ack || timed_out) begin
                    state_next     = DONE;
                    mem_req_next   = 1'b0;
                    mem_we_next    = 1'b0;
                    rsp_valid_next = 1'b1;
                    fault_next     = ~mem_ack;
                    rsp_rdata_next = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            we_reg        <= 1'b0;
            funct3_reg    <= 3'b000;
            lane_reg      <= 2'b00;
            wdata_reg     <= '0;
            cnt_reg       <= '0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            rsp_rdata_reg <= '0;
            rsp_valid_reg <= 1'b0;
            fault_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            we_reg        <= we_next;
            funct3_reg    <= funct3_next;
            lane_reg      <= lane_next;
            wdata_reg     <= wdata_next;
            cnt_reg       <= cnt_next;
            mem_req_reg   <= mem_req_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_valid_reg <= rsp_valid_next;
            fault_reg     <= fault_next;
        end
    end
endmodule

// File: tb/tb_lsu_rmw.sv
// Scoreboard bench for lsu_rmw: a behavioural byte-lane memory model predicts load
// data, faults, stall length and final memory contents for directed and random accesses.
module tb_lsu_rmw;
    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_we = 1'b0;
    logic [2:0]        req_funct3 = 3'b000;
    logic [31:0]       req_addr = '0;
    logic [31:0]       req_wdata = '0;
    logic              stall, rsp_valid, fault, mem_req, mem_we, mem_ack;
    logic [31:0]       rsp_rdata, mem_wdata, mem_rdata;
    logic [ADDR_W-1:0] mem_addr;

    always #5 clk = ~clk;

    lsu_rmw #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .fault(fault),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] seed_word(input int i);
        if (i == 25) return 32'h8899AABB;
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // Memory model: acks after ack_delay waiting cycles per request phase.
    logic [31:0] mem [256];
    logic        preload = 1'b1;
    int          ack_delay = 0;
    bit          never_ack = 1'b0;
    int          wait_cnt = 0;

    assign mem_ack   = mem_req && !never_ack && (wait_cnt == ack_delay);
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= seed_word(i);
        end else if (!reset && mem_req && mem_ack && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        if (reset || !mem_req || mem_ack) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    // Reference state and scoreboard.
    logic [31:0] ref_mem [256];
    typedef struct { logic [31:0] rdata; logic fault; int stalls; } exp_t;
    exp_t exp_q[$];

    assert property (@(posedge clk) disable iff (reset) stall |=> req_valid)
        else $error("protocol: req_valid dropped while stalled");

    int stall_cnt = 0;
    int txn = 0;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset) begin
            stall_cnt = 0;
        end else if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: got rdata 0x%08h with empty queue, expected none", rsp_rdata);
            end else begin
                e = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_fault", 32'(fault), 32'(e.fault));
                check("stall_cycles", stall_cnt, e.stalls);
                $display("txn %0d: rdata=0x%08h fault=%0d stall_cycles=%0d", txn, rsp_rdata, fault, stall_cnt);
            end
            txn++;
            stall_cnt = 0;
        end else if (stall) begin
            stall_cnt++;
        end
    end

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int delay, input bit no_ack);
        exp_t        e;
        int          nbytes, wi, sh, phases, exp_req, req_cycles;
        bit          legal, got;
        logic [31:0] mask, val;
        nbytes = 1 << f3[1:0];
        legal  = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        if (legal && (addr % nbytes) != 0) legal = 1'b0;
        wi     = int'(addr[9:2]);
        sh     = int'(addr[1:0]) * 8;
        mask   = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
        phases = 0;
        e.rdata = '0;
        e.fault = 1'b0;
        if (!legal) begin
            e.fault = 1'b1;
        end else if (no_ack) begin
            e.fault = 1'b1;
        end else if (!we) begin
            val = (ref_mem[wi] >> sh) & mask;
            if (!f3[2] && nbytes < 4 && val[8 * nbytes - 1]) val = val | ~mask;
            e.rdata = val;
            phases = 1;
        end else begin
            ref_mem[wi] = (ref_mem[wi] & ~(mask << sh)) | ((wdata & mask) << sh);
            phases = (nbytes == 4) ? 1 : 2;
        end
        if (legal && no_ack) begin
            e.stalls = 1 + TIMEOUT;
            exp_req  = TIMEOUT;
        end else begin
            e.stalls = 1 + phases * (delay + 1);
            exp_req  = phases * (delay + 1);
        end

        @(posedge clk);
        #1;
        ack_delay  = delay;
        never_ack  = no_ack;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        exp_q.push_back(e);
        req_cycles = 0;
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            if (mem_req) req_cycles++;
            if (rsp_valid) got = 1'b1;
        end
        check("rsp_seen", 32'(got), 32'd1);
        check("mem_req_cycles", req_cycles, exp_req);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        never_ack = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [31:0] r;
        logic [2:0]  f3;
        logic [31:0] addr;
        bit          found;
        for (int i = 0; i < 256; i++) ref_mem[i] = seed_word(i);

        repeat (2) @(negedge clk);
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_fault", 32'(fault), 32'd0);
        check("reset_mem_req", 32'(mem_req), 32'd0);
        check("reset_mem_we", 32'(mem_we), 32'd0);
        check("reset_mem_addr", 32'(mem_addr), 32'd0);
        check("reset_mem_wdata", mem_wdata, 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        @(posedge clk);
        #1;
        preload = 1'b0;
        reset   = 1'b0;

        issue(1'b0, 3'b000, 32'h65, 32'h0, 0, 1'b0);          // lb
        issue(1'b0, 3'b101, 32'h66, 32'h0, 0, 1'b0);          // lhu
        issue(1'b0, 3'b001, 32'h66, 32'h0, 0, 1'b0);          // lh
        issue(1'b0, 3'b010, 32'h64, 32'h0, 0, 1'b0);          // lw
        issue(1'b1, 3'b000, 32'h67, 32'h11, 3, 1'b0);         // sb, slow memory
        check("sb_mem25", mem[25], 32'h1199AABB);
        issue(1'b0, 3'b010, 32'h64, 32'h0, 1, 1'b0);
        issue(1'b1, 3'b010, 32'h64, 32'd25, 0, 1'b0);         // sw
        check("sw_mem25", mem[25], 32'h00000019);
        issue(1'b0, 3'b010, 32'h62, 32'h0, 0, 1'b0);          // misaligned lw
        issue(1'b1, 3'b001, 32'h65, 32'h1234, 0, 1'b0);       // misaligned sh
        issue(1'b0, 3'b011, 32'h64, 32'h0, 0, 1'b0);          // illegal funct3
        issue(1'b0, 3'b010, 32'h64, 32'h0, 0, 1'b1);          // lw timeout
        issue(1'b1, 3'b000, 32'h65, 32'hAB, 0, 1'b1);         // sb timeout in RD

        // Reset pulsed while an sb sits in its write phase.
        @(posedge clk);
        #1;
        ack_delay  = 5;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h66;
        req_wdata  = 32'h77;
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge clk);
            if (mem_req && mem_we) found = 1'b1;
        end
        check("reached_wr", 32'(found), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_mem25_kept", mem[25], ref_mem[25]);
        issue(1'b0, 3'b010, 32'h64, 32'h0, 0, 1'b0);

        for (int n = 0; n < 150; n++) begin
            r    = $urandom();
            f3   = 3'($urandom_range(0, 7));
            addr = {r[31:10], 8'($urandom_range(0, 31)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 1) == 1) addr = addr & ~((32'd1 << f3[1:0]) - 32'd1);
            issue(1'($urandom_range(0, 1)), f3, addr, $urandom(), $urandom_range(0, 2), 1'b0);
        end

        repeat (3) @(posedge clk);
        for (int i = 0; i < 32; i++) check($sformatf("final_mem[%0d]", i), mem[i], ref_mem[i]);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
